// File: rtl/cpu_io_responder.sv
// ---------------------------------------------------------------------------
// cpu_io_responder
//
// Responder for the I/O window (mem_a[17:16] == 2'b11) of the CPU's
// byte-wide memory bus. It sits beside the RAM in the top level and:
//   - decodes CPU reads/writes at 0x30000 / 0x30004 (offset = mem_a[3:0]),
//   - returns read data one cycle after the request (io_rd_sel marks it),
//   - buffers output bytes in a TX FIFO towards the UART,
//   - runs a free-running 32-bit clock counter with a coherent snapshot,
//   - flags the end of the program (program_done / done_flushed).
//
// Optional feature macro: IO_DROP_COUNT_EN
//   When defined, an 8-bit saturating counter of bytes dropped on a push into
//   a full FIFO is readable at 0x30008 and cleared by any write there.
//   When undefined, 0x30008 behaves like any unmapped offset.
//
// Parameters:
//   TX_DEPTH     TX FIFO entries (power of two, >= 4)
//   FULL_MARGIN  io_buffer_full asserts at occupancy >= TX_DEPTH-FULL_MARGIN
//
// Ports:
//   clk_in, rst_in        clock, asynchronous active-high reset
//   rdy_in                bus accesses accepted only while high
//   mem_a, mem_dout,      CPU address, write data, write strobe (0 = read)
//   mem_wr
//   io_rd_data, io_rd_sel read data and its valid/select, one cycle later
//   io_buffer_full        TX FIFO near-full back-pressure to the CPU
//   tx_data, tx_valid,    FIFO head towards the UART (valid/ready)
//   tx_ready
//   rx_data, rx_valid,    UART receive side; rx_pop pops the RX buffer
//   rx_pop
//   program_done          sticky end-of-program flag
//   done_flushed          program_done and TX FIFO drained
// ---------------------------------------------------------------------------
module cpu_io_responder #(
  parameter int unsigned TX_DEPTH    = 16,
  parameter int unsigned FULL_MARGIN = 4
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [31:0] mem_a,
  input  logic [7:0]  mem_dout,
  input  logic        mem_wr,
  output logic [7:0]  io_rd_data,
  output logic        io_rd_sel,
  output logic        io_buffer_full,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_pop,
  output logic        program_done,
  output logic        done_flushed
);

  localparam int unsigned PTR_W = $clog2(TX_DEPTH);
  localparam logic [PTR_W:0] DEPTH_C     = (PTR_W+1)'(TX_DEPTH);
  localparam logic [PTR_W:0] FULL_THRESH = (PTR_W+1)'(TX_DEPTH - FULL_MARGIN);

  // Bus decode
  logic       io_hit;
  logic       wr_access;
  logic       rd_access;
  logic [3:0] offset;
  logic       unused_addr_bits;

  // Clock counter and snapshot
  logic [31:0] clk_cnt;
  logic [31:0] snapshot;

  // TX FIFO
  logic [7:0]       fifo_mem [TX_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] rd_ptr_inc;
  logic [PTR_W:0]   count;
  logic [PTR_W:0]   count_next;
  logic             full;
  logic             push_req;
  logic [7:0]       push_byte;
  logic             push_ok;
  logic             pop;
  logic [7:0]       head_next;

  // Read path
  logic [7:0] rd_byte;
  logic [7:0] drop_rd;

  assign io_hit    = rdy_in && (mem_a[17:16] == 2'b11);
  assign wr_access = io_hit && mem_wr;
  assign rd_access = io_hit && !mem_wr;
  assign offset    = mem_a[3:0];

  // Only bits [17:16] and [3:0] take part in the decode.
  assign unused_addr_bits = ^{mem_a[31:18], mem_a[15:4]};

  // Free-running cycle counter; wraps naturally at 32 bits and ignores rdy_in.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      clk_cnt <= 32'h0;
    end else begin
      clk_cnt <= clk_cnt + 32'h1;
    end
  end

  // Write decode: 0x30000 pushes non-zero bytes, 0x30004 always pushes a
  // 0x00 terminator so the UART side sees the end of output.
  always_comb begin
    push_req  = 1'b0;
    push_byte = 8'h00;
    if (wr_access) begin
      case (offset)
        4'h0: begin
          if (mem_dout != 8'h00) begin
            push_req  = 1'b1;
            push_byte = mem_dout;
          end
        end
        4'h4: begin
          push_req  = 1'b1;
          push_byte = 8'h00;
        end
        default: begin
          push_req  = 1'b0;
          push_byte = 8'h00;
        end
      endcase
    end
  end

  assign tx_valid       = (count != '0);
  assign full           = (count == DEPTH_C);
  assign io_buffer_full = (count >= FULL_THRESH);
  assign done_flushed   = program_done && (count == '0);
  assign pop            = tx_valid && tx_ready;
  // A pop in the same cycle frees the slot, so a push into a full FIFO
  // still lands when the UART is draining.
  assign push_ok        = push_req && (!full || pop);
  assign rd_ptr_inc     = rd_ptr + PTR_W'(1);

  always_comb begin
    count_next = count;
    case ({push_ok, pop})
      2'b10:   count_next = count + (PTR_W+1)'(1);
      2'b01:   count_next = count - (PTR_W+1)'(1);
      default: count_next = count;
    endcase
  end

  // tx_data is a register that always holds the current head, so it is stable
  // while the UART stalls. After a pop the new head is the next stored entry,
  // or the byte being pushed this cycle when the FIFO held only one entry.
  always_comb begin
    head_next = tx_data;
    if (pop) begin
      if (count > (PTR_W+1)'(1)) begin
        head_next = fifo_mem[rd_ptr_inc];
      end else if (push_ok) begin
        head_next = push_byte;
      end
    end else if ((count == '0) && push_ok) begin
      head_next = push_byte;
    end
  end

  // FIFO storage carries no reset; the pointers and count define validity.
  always_ff @(posedge clk_in) begin
    if (push_ok) begin
      fifo_mem[wr_ptr] <= push_byte;
    end
  end

  // FIFO pointers, occupancy and the registered head byte.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      tx_data <= 8'h00;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr_inc;
      end
      count   <= count_next;
      tx_data <= head_next;
    end
  end

  // Sticky end-of-program flag.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      program_done <= 1'b0;
    end else if (wr_access && (offset == 4'h4)) begin
      program_done <= 1'b1;
    end
  end

`ifdef IO_DROP_COUNT_EN
  logic [7:0] drop_cnt;
  logic       push_drop;
  logic       drop_clr;

  assign push_drop = push_req && full && !pop;
  assign drop_clr  = wr_access && (offset == 4'h8);

  // Saturating count of bytes lost to a full FIFO; any write to 0x30008 clears.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      drop_cnt <= 8'h00;
    end else if (drop_clr) begin
      drop_cnt <= 8'h00;
    end else if (push_drop && (drop_cnt != 8'hFF)) begin
      drop_cnt <= drop_cnt + 8'h01;
    end
  end

  assign drop_rd = drop_cnt;
`else
  assign drop_rd = 8'h00;
`endif

  // The RX buffer is popped in the request cycle so the byte it presents now
  // is the one returned next cycle. Held off during reset.
  assign rx_pop = rd_access && (offset == 4'h0) && rx_valid && !rst_in;

  // Read mux. Byte 0 of the counter comes straight from the live counter,
  // which is the same value latched into the snapshot on that edge; bytes
  // 1..3 come from the snapshot so a 4-byte load is coherent.
  always_comb begin
    rd_byte = 8'h00;
    case (offset)
      4'h0:    rd_byte = rx_valid ? rx_data : 8'h00;
      4'h4:    rd_byte = clk_cnt[7:0];
      4'h5:    rd_byte = snapshot[15:8];
      4'h6:    rd_byte = snapshot[23:16];
      4'h7:    rd_byte = snapshot[31:24];
      4'h8:    rd_byte = drop_rd;
      default: rd_byte = 8'h00;
    endcase
  end

  // Registered read response; io_rd_data holds between reads.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      io_rd_data <= 8'h00;
      io_rd_sel  <= 1'b0;
      snapshot   <= 32'h0;
    end else begin
      io_rd_sel <= rd_access;
      if (rd_access) begin
        io_rd_data <= rd_byte;
        if (offset == 4'h4) begin
          snapshot <= clk_cnt;
        end
      end
    end
  end

endmodule

// File: tb/tb_cpu_io_responder.sv
// ---------------------------------------------------------------------------
// tb_cpu_io_responder
//
// Directed bench for cpu_io_responder with hand-computed expectations.
// Inputs are driven 1 time unit after the rising edge and outputs are
// sampled at that same point, away from the active edge.
// ---------------------------------------------------------------------------
module tb_cpu_io_responder;

  logic        clk_in;
  logic        rst_in;
  logic        rdy_in;
  logic [31:0] mem_a;
  logic [7:0]  mem_dout;
  logic        mem_wr;
  logic [7:0]  io_rd_data;
  logic        io_rd_sel;
  logic        io_buffer_full;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_pop;
  logic        program_done;
  logic        done_flushed;

  int total;
  int bad;

  cpu_io_responder #(
    .TX_DEPTH   (16),
    .FULL_MARGIN(4)
  ) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .rdy_in        (rdy_in),
    .mem_a         (mem_a),
    .mem_dout      (mem_dout),
    .mem_wr        (mem_wr),
    .io_rd_data    (io_rd_data),
    .io_rd_sel     (io_rd_sel),
    .io_buffer_full(io_buffer_full),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rx_pop        (rx_pop),
    .program_done  (program_done),
    .done_flushed  (done_flushed)
  );

  // 10-unit clock period.
  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // Compare one observed value against its expectation and count it.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // One accepted bus cycle (rdy_in high), then return the bus to idle.
  task automatic applyStimulus(input logic wr, input logic [31:0] addr, input logic [7:0] data);
    rdy_in   = 1'b1;
    mem_wr   = wr;
    mem_a    = addr;
    mem_dout = data;
    tick();
    rdy_in   = 1'b0;
    mem_wr   = 1'b0;
    mem_a    = 32'h0;
    mem_dout = 8'h00;
  endtask

  initial begin
    logic [7:0] exp_byte;
    total    = 0;
    bad      = 0;
    rst_in   = 1'b1;
    rdy_in   = 1'b0;
    mem_a    = 32'h0;
    mem_dout = 8'h00;
    mem_wr   = 1'b0;
    tx_ready = 1'b0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;

    // ---- reset state ----
    tick();
    tick();
    checkOutput("rst_tx_valid",  32'(tx_valid), 32'h0);
    checkOutput("rst_tx_data",   32'(tx_data), 32'h0);
    checkOutput("rst_rd_sel",    32'(io_rd_sel), 32'h0);
    checkOutput("rst_rd_data",   32'(io_rd_data), 32'h0);
    checkOutput("rst_full",      32'(io_buffer_full), 32'h0);
    checkOutput("rst_done",      32'(program_done), 32'h0);
    checkOutput("rst_flushed",   32'(done_flushed), 32'h0);
    checkOutput("rst_rx_pop",    32'(rx_pop), 32'h0);
    rst_in = 1'b0;
    tick();

    // ---- writes that must be ignored ----
    mem_a = 32'h0003_0000; mem_wr = 1'b1; mem_dout = 8'h33; rdy_in = 1'b0;
    tick();
    mem_a = 32'h0; mem_wr = 1'b0; mem_dout = 8'h00;
    checkOutput("ign_rdy_low", 32'(tx_valid), 32'h0);
    applyStimulus(1'b1, 32'h0003_0002, 8'h34);
    checkOutput("ign_offset2", 32'(tx_valid), 32'h0);
    applyStimulus(1'b1, 32'h0001_0000, 8'h35);
    checkOutput("ign_non_io", 32'(tx_valid), 32'h0);

    // ---- basic TX: 0x41, 0x00 (ignored), 0x42 ----
    applyStimulus(1'b1, 32'h0003_0000, 8'h41);
    applyStimulus(1'b1, 32'h0003_0000, 8'h00);
    applyStimulus(1'b1, 32'h0003_0000, 8'h42);
    checkOutput("tx_valid_q", 32'(tx_valid), 32'h1);
    checkOutput("tx_head_41", 32'(tx_data), 32'h41);
    tick();
    checkOutput("tx_hold_41", 32'(tx_data), 32'h41);
    tx_ready = 1'b1;
    tick();
    checkOutput("tx_head_42", 32'(tx_data), 32'h42);
    checkOutput("tx_valid_1", 32'(tx_valid), 32'h1);
    tick();
    checkOutput("tx_empty", 32'(tx_valid), 32'h0);
    tx_ready = 1'b0;

    // ---- fill: 11 pushes below threshold, 12th asserts full ----
    for (int i = 1; i <= 11; i++) begin
      applyStimulus(1'b1, 32'h0003_0000, 8'(i));
    end
    checkOutput("full_at_11", 32'(io_buffer_full), 32'h0);
    applyStimulus(1'b1, 32'h0003_0000, 8'h0C);
    checkOutput("full_at_12", 32'(io_buffer_full), 32'h1);
    // 6 more: 4 accepted (to 16), 2 dropped
    for (int i = 13; i <= 18; i++) begin
      applyStimulus(1'b1, 32'h0003_0000, 8'(i));
    end
    checkOutput("full_head", 32'(tx_data), 32'h01);
`ifdef IO_DROP_COUNT_EN
    applyStimulus(1'b0, 32'h0003_0008, 8'h00);
    checkOutput("drop_cnt_2", 32'(io_rd_data), 32'h02);
    applyStimulus(1'b1, 32'h0003_0008, 8'h99);
    applyStimulus(1'b0, 32'h0003_0008, 8'h00);
    checkOutput("drop_cnt_clr", 32'(io_rd_data), 32'h00);
`else
    applyStimulus(1'b0, 32'h0003_0008, 8'h00);
    checkOutput("off8_unmapped", 32'(io_rd_data), 32'h00);
`endif
    // push while full with a simultaneous pop
    tx_ready = 1'b1;
    applyStimulus(1'b1, 32'h0003_0000, 8'h55);
    tx_ready = 1'b0;
    checkOutput("pp_full_kept", 32'(io_buffer_full), 32'h1);
    checkOutput("pp_head_02", 32'(tx_data), 32'h02);
    // drain: 0x02..0x10 then 0x55
    tx_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      exp_byte = (i == 15) ? 8'h55 : 8'(i + 2);
      checkOutput($sformatf("drain_%0d", i), 32'(tx_data), 32'(exp_byte));
      tick();
    end
    checkOutput("drain_empty", 32'(tx_valid), 32'h0);
    checkOutput("drain_not_full", 32'(io_buffer_full), 32'h0);
    tx_ready = 1'b0;

    // ---- counter snapshot: read 0x30004 when counter is 0x1FF ----
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    repeat (511) tick();
    applyStimulus(1'b0, 32'h0003_0004, 8'h00);
    checkOutput("snap_b0", 32'(io_rd_data), 32'hFF);
    checkOutput("snap_b0_sel", 32'(io_rd_sel), 32'h1);
    applyStimulus(1'b0, 32'h0000_0004, 8'h00);
    checkOutput("nonio_sel", 32'(io_rd_sel), 32'h0);
    checkOutput("nonio_hold", 32'(io_rd_data), 32'hFF);
    applyStimulus(1'b0, 32'h0003_000C, 8'h00);
    checkOutput("unmapped_rd", 32'(io_rd_data), 32'h00);
    checkOutput("unmapped_sel", 32'(io_rd_sel), 32'h1);
    applyStimulus(1'b0, 32'h0003_0005, 8'h00);
    checkOutput("snap_b1", 32'(io_rd_data), 32'h01);
    checkOutput("snap_b1_sel", 32'(io_rd_sel), 32'h1);
    applyStimulus(1'b0, 32'h0003_0006, 8'h00);
    checkOutput("snap_b2", 32'(io_rd_data), 32'h00);
    checkOutput("snap_b2_sel", 32'(io_rd_sel), 32'h1);
    applyStimulus(1'b0, 32'h0003_0007, 8'h00);
    checkOutput("snap_b3", 32'(io_rd_data), 32'h00);
    checkOutput("snap_b3_sel", 32'(io_rd_sel), 32'h1);
    tick();
    checkOutput("sel_one_cycle", 32'(io_rd_sel), 32'h0);

    // ---- RX reads ----
    rx_valid = 1'b1;
    rx_data  = 8'h37;
    rdy_in = 1'b1; mem_wr = 1'b0; mem_a = 32'h0003_0000;
    #1;
    checkOutput("rx_pop_req", 32'(rx_pop), 32'h1);
    @(posedge clk_in);
    #1;
    rdy_in = 1'b0; mem_a = 32'h0; rx_valid = 1'b0; rx_data = 8'h00;
    #1;
    checkOutput("rx_data_37", 32'(io_rd_data), 32'h37);
    checkOutput("rx_sel", 32'(io_rd_sel), 32'h1);
    checkOutput("rx_pop_done", 32'(rx_pop), 32'h0);
    rdy_in = 1'b1; mem_a = 32'h0003_0000;
    #1;
    checkOutput("rx_nopop", 32'(rx_pop), 32'h0);
    @(posedge clk_in);
    #1;
    rdy_in = 1'b0; mem_a = 32'h0;
    checkOutput("rx_empty_00", 32'(io_rd_data), 32'h00);
    checkOutput("rx_empty_sel", 32'(io_rd_sel), 32'h1);

    // ---- program done and flush ----
    applyStimulus(1'b1, 32'h0003_0000, 8'h61);
    applyStimulus(1'b1, 32'h0003_0000, 8'h62);
    applyStimulus(1'b1, 32'h0003_0000, 8'h63);
    checkOutput("pre_done", 32'(program_done), 32'h0);
    applyStimulus(1'b1, 32'h0003_0004, 8'hAA);
    checkOutput("done_set", 32'(program_done), 32'h1);
    checkOutput("done_not_flushed", 32'(done_flushed), 32'h0);
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_byte = (i == 3) ? 8'h00 : 8'(8'h61 + i);
      checkOutput($sformatf("flush_%0d", i), 32'(tx_data), 32'(exp_byte));
      checkOutput($sformatf("flush_wait_%0d", i), 32'(done_flushed), 32'h0);
      tick();
    end
    checkOutput("flushed", 32'(done_flushed), 32'h1);
    checkOutput("flushed_empty", 32'(tx_valid), 32'h0);
    checkOutput("done_sticky", 32'(program_done), 32'h1);

    // ---- reset mid-drain with a pending read response ----
    tx_ready = 1'b0;
    applyStimulus(1'b1, 32'h0003_0000, 8'h71);
    applyStimulus(1'b1, 32'h0003_0000, 8'h72);
    tx_ready = 1'b1;
    applyStimulus(1'b0, 32'h0003_0005, 8'h00);
    checkOutput("mid_sel", 32'(io_rd_sel), 32'h1);
    checkOutput("mid_head_72", 32'(tx_data), 32'h72);
    #2;
    rst_in = 1'b1;
    #1;
    checkOutput("arst_tx_valid", 32'(tx_valid), 32'h0);
    checkOutput("arst_tx_data", 32'(tx_data), 32'h0);
    checkOutput("arst_rd_sel", 32'(io_rd_sel), 32'h0);
    checkOutput("arst_rd_data", 32'(io_rd_data), 32'h0);
    checkOutput("arst_done", 32'(program_done), 32'h0);
    checkOutput("arst_flushed", 32'(done_flushed), 32'h0);
    checkOutput("arst_full", 32'(io_buffer_full), 32'h0);
    tx_ready = 1'b0;
    tick();
    rst_in = 1'b0;
    tick();
    checkOutput("post_rst_empty", 32'(tx_valid), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cpu_io_responder.md
Name: cpu_io_responder

Overview:
- Responder side of the CPU's byte-wide memory bus for the I/O window (mem_a[17:16]==2'b11); sits beside the RAM in the top level.
- Decodes CPU reads and writes at 0x30000/0x30004 and returns read data one cycle later.
- Buffers output bytes in a TX FIFO towards the UART and drives io_buffer_full back to the CPU.
- Provides the free-running clock counter and the program-stop indication.

Parameters:
- TX_DEPTH, 16, TX FIFO entries (power of two, >=4).
- FULL_MARGIN, 4, io_buffer_full asserts when occupancy >= TX_DEPTH-FULL_MARGIN; covers CPU writes already in flight.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  reset, asynchronous, active-high.
- rdy_in  input  1  bus accesses accepted only when high.
- mem_a  input  32  CPU address bus.
- mem_dout  input  8  CPU write data.
- mem_wr  input  1  1=write, 0=read.
- io_rd_data  output  8  read data, valid the cycle after an I/O read.
- io_rd_sel  output  1  high the cycle after an accepted I/O read; top level uses it to mux io_rd_data onto mem_din.
- io_buffer_full  output  1  TX FIFO near-full.
- tx_data  output  8  FIFO head byte.
- tx_valid  output  1  FIFO non-empty.
- tx_ready  input  1  UART accepts tx_data when tx_valid&&tx_ready.
- rx_data  input  8  received UART byte.
- rx_valid  input  1  rx_data available.
- rx_pop  output  1  1-cycle pop strobe to the RX buffer.
- program_done  output  1  sticky; set by a write to 0x30004.
- done_flushed  output  1  program_done && TX FIFO empty.

Behaviour:
- Reset: all outputs 0; FIFO empty; clock counter 0; snapshot 0; program_done 0.
- Access accepted when rdy_in && mem_a[17:16]==2'b11. Decode uses mem_a[3:0]. Non-I/O addresses: no effect, io_rd_sel 0 next cycle.
- Clock counter: 32-bit, +1 every clk_in cycle independent of rdy_in, wraps 0xFFFFFFFF->0.
- Write 0x30000: mem_dout!=0 pushes the byte into the FIFO; 0x00 is ignored.
- Write 0x30004: sets program_done and pushes 0x00 into the FIFO. Subsequent writes keep the flag set and still push 0x00.
- Writes to other I/O offsets are ignored.
- Push while FIFO full: byte dropped, FIFO unchanged.
- Simultaneous push and pop: both occur and occupancy is unchanged. When full, the pop frees the slot and the push is accepted.
- Read 0x30000:
  - rx_valid=1: rx_pop pulses in the request cycle; io_rd_data=rx_data on the next cycle.
  - rx_valid=0: io_rd_data=0x00 next cycle; no pop.
- Read 0x30004: latches the snapshot from the current counter value and returns byte 0 next cycle.
- Read 0x30005/6/7: returns snapshot bytes 1/2/3 without re-latching, so a 4-byte load is coherent.
- Read of any other I/O offset returns 0x00.
- io_rd_sel=1 exactly one cycle after each accepted I/O read. io_rd_data holds its last value otherwise.
- tx_valid = occupancy!=0; tx_data = head byte, registered, stable while tx_valid && !tx_ready.
- io_buffer_full is combinational from occupancy.
- rdy_in low: no pushes, no pops from the CPU side; TX draining and the counter continue.
- Reset mid-operation: FIFO contents discarded; pending io_rd_sel cleared.

Optional Feature:
- IO_DROP_COUNT_EN defined:
  - 8-bit saturating counter of bytes dropped on a full-FIFO push.
  - Read 0x30008 returns it.
  - Write 0x30008 (any data) clears it.
- IO_DROP_COUNT_EN not defined: 0x30008 behaves as an unmapped offset (reads 0x00); no counter logic.

Test Plan:
- Write 0x41,0x00,0x42 to 0x30000 with tx_ready=0 -> occupancy 2; tx_data=0x41; after tx_ready=1, bytes 0x41 then 0x42 out.
- Push 12 bytes (TX_DEPTH=16, FULL_MARGIN=4), tx_ready=0 -> io_buffer_full rises at the 12th push. Push 6 more -> 2 dropped; with IO_DROP_COUNT_EN, read 0x30008 returns 0x02.
- Full FIFO, tx_ready=1 and push 0x55 in the same cycle -> occupancy stays 16; 0x55 is last out.
- Counter at 0x000001FF when 0x30004 is read, then 0x30005..7 read over 3 cycles -> bytes 0xFF,0x01,0x00,0x00 on io_rd_data, each with io_rd_sel=1.
- Read 0x30000: rx_valid=1, rx_data=0x37 -> rx_pop 1 cycle, next cycle io_rd_data=0x37. With rx_valid=0 -> 0x00, no pop.
- Write 0x30004 with 3 bytes queued, tx_ready=1 -> program_done immediately. done_flushed rises after 4 bytes (last 0x00) leave. Assert rst_in mid-drain -> all outputs 0 asynchronously.
